// File: rtl/cos_range_reduce_if.sv
// Handshake bundle between the angle requester, the range reducer and the cosine core.
// The slave side is the reducer; the master side drives requests and the core responses.
interface cos_range_reduce_if;
  logic        start;
  logic [31:0] angle;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cos_out;
  logic [31:0] xita_o;
  logic        cos_valid;
  logic [31:0] cos_in;

  modport slave (
    input  start, angle, cos_valid, cos_in,
    output busy, done, err, cos_out, xita_o
  );

  modport master (
    output start, angle, cos_valid, cos_in,
    input  busy, done, err, cos_out, xita_o
  );
endinterface

// File: rtl/cos_range_reduce.sv
// Folds any signed Q16.16 angle into [0, pi/2] for the cosine core, then restores the sign
// of the core's result. The pi/2 point is answered directly so the core never sees it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; |angle| latched on accept
// S_REDUCE | 13 restoring-subtract steps of 2*pi<<k, k = 12..0
// S_FOLD1  | map (pi, 2*pi) onto (0, pi)
// S_FOLD2  | pi/2 short-cut, else drive xita_o and pick result sign
// S_SETTLE | core output not trusted while it reacts to xita_o
// S_WAIT   | take first cos_valid, or give up at terminal count
// S_DONE   | publish result; done/busy/err update on leaving
module cos_range_reduce #(
  parameter logic [31:0] TWO_PI  = 32'h0006_487F,
  parameter logic [31:0] PI      = 32'h0003_243F,
  parameter logic [31:0] PI_HALF = 32'h0001_9220,
  parameter int          SETTLE  = 2,
  parameter int          TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cos_range_reduce_if.slave bus
);

  localparam int SW = (SETTLE  > 1) ? $clog2(SETTLE + 1)  : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_FOLD1,
    S_FOLD2,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [32:0]   r_a,       w_a_nxt;
  logic [3:0]    r_k,       w_k_nxt;
  logic          r_neg,     w_neg_nxt;
  logic [SW-1:0] r_settle,  w_settle_nxt;
  logic [TW-1:0] r_tmr,     w_tmr_nxt;
  logic [31:0]   r_result,  w_result_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [31:0]   r_xita,    w_xita_nxt;
  logic          r_busy,    w_busy_nxt;
  logic          r_done,    w_done_nxt;
  logic          r_err,     w_err_nxt;
  logic [31:0]   r_cos_out, w_cos_nxt;

  logic [32:0]   w_abs;
  logic [32:0]   w_sub;

  // Inverting before the increment keeps 0x8000_0000 as +2^31 in 33 bits.
  assign w_abs = bus.angle[31] ? ({1'b0, ~bus.angle} + 33'd1) : {1'b0, bus.angle};
  assign w_sub = {1'b0, TWO_PI} << r_k;

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_k_nxt       = r_k;
    w_neg_nxt     = r_neg;
    w_settle_nxt  = r_settle;
    w_tmr_nxt     = r_tmr;
    w_result_nxt  = r_result;
    w_timeout_nxt = r_timeout;
    w_xita_nxt    = r_xita;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_cos_nxt     = r_cos_out;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = w_abs;
          w_k_nxt     = 4'd12;
          w_err_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (r_a >= w_sub) w_a_nxt = r_a - w_sub;
        if (r_k == 4'd0) w_state_nxt = S_FOLD1;
        else             w_k_nxt     = r_k - 4'd1;
      end
      S_FOLD1: begin
        if (r_a > {1'b0, PI}) w_a_nxt = {1'b0, TWO_PI} - r_a;
        w_state_nxt = S_FOLD2;
      end
      S_FOLD2: begin
        if (r_a == {1'b0, PI_HALF}) begin
          w_result_nxt  = 32'd0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = S_DONE;
        end else begin
          if (r_a > {1'b0, PI_HALF}) begin
            w_xita_nxt = PI - r_a[31:0];
            w_neg_nxt  = 1'b1;
          end else begin
            w_xita_nxt = r_a[31:0];
            w_neg_nxt  = 1'b0;
          end
          w_settle_nxt = SW'(SETTLE - 1);
          w_tmr_nxt    = TW'(TIMEOUT - 1);
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle == '0) w_state_nxt  = S_WAIT;
        else                w_settle_nxt = r_settle - SW'(1);
      end
      S_WAIT: begin
        if (bus.cos_valid) begin
          w_result_nxt  = r_neg ? (~bus.cos_in + 32'd1) : bus.cos_in;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = S_DONE;
        end else if (r_tmr == '0) begin
          w_result_nxt  = 32'd0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_tmr_nxt = r_tmr - TW'(1);
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_err_nxt   = r_timeout;
        w_cos_nxt   = r_result;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_k       <= '0;
      r_neg     <= 1'b0;
      r_settle  <= '0;
      r_tmr     <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_xita    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cos_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_k       <= w_k_nxt;
      r_neg     <= w_neg_nxt;
      r_settle  <= w_settle_nxt;
      r_tmr     <= w_tmr_nxt;
      r_result  <= w_result_nxt;
      r_timeout <= w_timeout_nxt;
      r_xita    <= w_xita_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_cos_out <= w_cos_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.cos_out = r_cos_out;
  assign bus.xita_o  = r_xita;

endmodule

// File: tb/tb_cos_range_reduce.sv
// Randomised and directed bench for cos_range_reduce with a behavioural cosine-core model.
// Expected results are queued at each start and compared by an independent done monitor.
module tb_cos_range_reduce;

  localparam logic [31:0] TWO_PI  = 32'h0006_487F;
  localparam logic [31:0] PI      = 32'h0003_243F;
  localparam logic [31:0] PI_HALF = 32'h0001_9220;
  localparam int          SETTLE  = 2;
  localparam int          TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cos_range_reduce_if bus();

  cos_range_reduce dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] cos;
    logic        err;
    logic [31:0] xita;
    int          t0;
    int          lat;
  } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Core model: valid drops whenever xita changes and returns core_delay cycles later.
  logic [31:0] core_val   = 32'd0;
  int          core_delay = 0;
  bit          core_en    = 1'b0;
  logic [31:0] last_x     = 32'd0;
  int          since      = 100;

  always @(posedge clk) begin
    #1;
    if (bus.xita_o !== last_x) begin
      last_x = bus.xita_o;
      since  = 0;
    end else if (since < 1000) begin
      since++;
    end
    bus.cos_valid = core_en && (since >= core_delay);
    bus.cos_in    = core_val;
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = q.pop_front();
        check32("cos_out", bus.cos_out, e.cos);
        check32("err", {31'd0, bus.err}, {31'd0, e.err});
        check32("xita_o", bus.xita_o, e.xita);
        check32("latency", cyc - e.t0, e.lat);
        check32("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  logic [31:0] model_prev_x = 32'd0;

  // Reference: |angle| mod 2pi, mirror about pi, then about pi/2.
  task automatic model(input logic [31:0] ang, input logic [31:0] cval, input int dly,
                       input bit en, output exp_t r);
    longint a;
    logic [31:0] x;
    bit neg;
    int w;
    a = longint'($signed(ang));
    if (a < 0) a = -a;
    a = a % longint'(TWO_PI);
    if (a > longint'(PI)) a = longint'(TWO_PI) - a;
    r.err = 1'b0;
    if (a == longint'(PI_HALF)) begin
      r.cos  = 32'd0;
      r.xita = model_prev_x;
      r.lat  = 1 + 13 + 2 + 1;
    end else begin
      if (a > longint'(PI_HALF)) begin
        x   = 32'(longint'(PI) - a);
        neg = 1'b1;
      end else begin
        x   = 32'(a);
        neg = 1'b0;
      end
      if (!en)                   w = TIMEOUT;
      else if (x == model_prev_x) w = 1;
      else                       w = (dly - 1 > 1) ? dly - 1 : 1;
      r.xita = x;
      r.lat  = 1 + 13 + 2 + SETTLE + w + 1;
      if (!en) begin
        r.cos = 32'd0;
        r.err = 1'b1;
      end else begin
        r.cos = neg ? (32'd0 - cval) : cval;
      end
      model_prev_x = x;
    end
  endtask

  // mode 0: plain, 1: extra start during REDUCE, 2: extra start in the DONE-state cycle
  task automatic run_txn(input logic [31:0] ang, input logic [31:0] cval, input int dly,
                         input bit en, input int mode);
    exp_t r;
    int n;
    model(ang, cval, dly, en, r);
    r.t0 = cyc;
    q.push_back(r);
    bus.start  = 1'b1;
    bus.angle  = ang;
    core_val   = cval;
    core_delay = dly;
    core_en    = en;
    @(negedge clk);
    bus.start = 1'b0;
    bus.angle = $urandom;
    check32("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check32("err_after_start", {31'd0, bus.err}, 32'd0);
    n = 1;
    while (bus.done !== 1'b1 && n < r.lat + 50) begin
      if (mode == 1 && cyc == r.t0 + 5)              bus.start = 1'b1;
      else if (mode == 2 && cyc == r.t0 + r.lat - 1) bus.start = 1'b1;
      else                                           bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    if (bus.done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_wait actual=timeout expected=done angle=%h", ang);
    end
  endtask

  task automatic reset_in_wait(input logic [31:0] ang);
    int t0;
    t0         = cyc;
    bus.start  = 1'b1;
    bus.angle  = ang;
    core_en    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("rst_busy", {31'd0, bus.busy}, 32'd0);
    check32("rst_xita", bus.xita_o, 32'd0);
    check32("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    model_prev_x = 32'd0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.angle     = 32'd0;
    bus.cos_valid = 1'b0;
    bus.cos_in    = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check32("reset_busy", {31'd0, bus.busy}, 32'd0);
    check32("reset_done", {31'd0, bus.done}, 32'd0);
    check32("reset_err", {31'd0, bus.err}, 32'd0);
    check32("reset_cos", bus.cos_out, 32'd0);
    check32("reset_xita", bus.xita_o, 32'd0);

    run_txn(32'h0000_0000, 32'h0001_0000, 5, 1'b1, 0);
    run_txn(PI,            32'h0001_0000, 5, 1'b1, 0);
    run_txn(32'hFFF8_B781, 32'h0000_8A51, 5, 1'b1, 0);
    run_txn(32'hFFF8_B781, 32'h0000_8A51, 5, 1'b1, 0);
    run_txn(32'h8000_0000, 32'h0000_1234, 3, 1'b1, 0);
    run_txn(PI_HALF,       32'h0000_7777, 0, 1'b1, 0);
    run_txn(32'h0004_B65F, 32'h0000_7777, 0, 1'b1, 0);
    run_txn(32'hFFFE_6DE0, 32'h0000_7777, 0, 1'b1, 0);
    run_txn(32'h0002_0000, 32'h0000_0000, 4, 1'b1, 0);
    run_txn(32'h0001_0000, 32'h0000_5555, 2, 1'b0, 0);
    run_txn(32'h0001_8000, 32'h0000_4000, 6, 1'b1, 0);
    run_txn(32'h0000_C000, 32'h0000_E000, 4, 1'b1, 1);
    run_txn(32'h0002_8000, 32'h0000_3000, 7, 1'b1, 2);
    run_txn(32'h7FFF_FFFF, 32'h0000_9000, 1, 1'b1, 0);

    reset_in_wait(32'h0000_4000);
    run_txn(32'h0000_4000, 32'h0000_F000, 5, 1'b1, 0);

    for (int i = 0; i < 30; i++) begin
      run_txn($urandom, $urandom_range(0, 32'h0001_0000), int'($urandom_range(0, 8)),
              1'b1, int'($urandom_range(0, 2)));
    end

    repeat (30) @(negedge clk);
    check32("pending_results", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
